// File: rtl/cpu_pkg.sv
// Shared mini-cpu types and constants: fetch FSM states, NOP encoding, opcodes.
// Imported by the fetch stage and the control decoder.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_out_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: async reset to RESET_PC, +4 step, aligned redirect load.
// Latency: new PC visible the cycle after inc/redirect; misalign pulse likewise.
// Backpressure: none; redirect always wins over inc.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic            misalign_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect && (redirect_pc[1:0] != 2'b00);
      if (redirect) begin
        pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (inc) begin
        // wraps modulo 2^32 by construction
        pc <= pc + XLEN'(4);
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding imem requests, fetched word held on valid/ready to decode.
// Latency: req+gnt in N, rvalid in N+1 -> instr_valid in N+2; one instr per 3 cycles peak.
// Backpressure: HOLD keeps instr stable and issues no request until instr_ready or redirect.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP      = NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err
);

  fetch_state_t    state, state_n;
  logic            drop, drop_n;
  logic            pc_inc;
  logic            load_instr;
  logic            clr_instr;
  logic [XLEN-1:0] pc;
  fetch_out_t      out_q;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (pc_inc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .misalign_err (misalign_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  always_comb begin
    state_n    = state;
    drop_n     = drop;
    pc_inc     = 1'b0;
    load_instr = 1'b0;
    clr_instr  = redirect;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_gnt) begin
          state_n = WAIT;
          // the granted fetch targets the old PC; its response must be discarded
          if (redirect) drop_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_n = REQ;
          drop_n  = 1'b0;
          if (!drop && !redirect) begin
            state_n    = HOLD;
            load_instr = 1'b1;
            pc_inc     = 1'b1;
          end
        end else if (redirect) begin
          drop_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || instr_ready) begin
          state_n   = REQ;
          clr_instr = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q.vld   <= 1'b0;
      out_q.instr <= NOP;
      out_q.pc    <= '0;
    end else if (load_instr) begin
      out_q.vld   <= 1'b1;
      out_q.instr <= imem_rdata;
      out_q.pc    <= pc;
    end else if (clr_instr) begin
      out_q.vld   <= 1'b0;
      out_q.instr <= NOP;
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = out_q.vld;
  assign instr       = out_q.instr;
  assign instr_pc    = out_q.pc;

endmodule
